// File: rtl/mem_lsu_if.sv
// Data-memory bus between the load/store unit and the memory slave.
// Latency: none, wires only.
// Backpressure: the request is held until req_ready; a response is one rsp_valid pulse.
// Ports: req_valid/req_ready handshake with req_we, req_addr, req_wdata, req_bmask;
//        rsp_valid qualifies rsp_rdata.
interface mem_lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_bmask;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_bmask,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_bmask,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: byte masks, store lane replication, misalign detection, response timeout.
// Latency: issue cycle + >=1 REQ cycle + >=1 RESP cycle, then a one-cycle DONE with registered o_rdata.
// Backpressure: o_stall holds the pipeline while a request waits for req_ready or a response.
// Ports: i_clk, i_reset (async active-low); pipeline side i_valid, i_mem_read, i_mem_write,
//        i_funct3, i_addr, i_wdata, i_flush; results o_stall, o_rdata, o_done, o_misaligned,
//        o_bus_err; bus is the master side of mem_lsu_if.
module mem_lsu #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_valid,
    input  logic        i_mem_read,
    input  logic        i_mem_write,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic        i_flush,
    output logic        o_stall,
    output logic [31:0] o_rdata,
    output logic        o_done,
    output logic        o_misaligned,
    output logic        o_bus_err,
    mem_lsu_if.master   bus
);

    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

    state_t             state, state_nxt;
    logic               access, misaligned, start;
    logic               is_byte, is_half;
    logic [3:0]         bmask_c;
    logic [31:0]        wdata_c;
    logic               we_q, kill_q, err_q;
    logic [1:0]         off_q;
    logic [31:0]        addr_q, wdata_q;
    logic [3:0]         bmask_q;
    logic [CNT_W-1:0]   cnt;
    logic               timeout_hit, kill_now;

    // Access decode; unused funct3 encodings fall through to word.
    always_comb begin
        is_byte = 1'b0;
        is_half = 1'b0;
        case (i_funct3)
            3'b000, 3'b100: is_byte = 1'b1;
            3'b001, 3'b101: is_half = 1'b1;
            default:        ;
        endcase
        access     = i_valid & (i_mem_read | i_mem_write) & ~i_flush;
        misaligned = (is_half & i_addr[0]) | (~is_byte & ~is_half & (i_addr[1:0] != 2'b00));
        start      = access & ~misaligned;
        if (is_byte) begin
            bmask_c = 4'b0001 << i_addr[1:0];
            wdata_c = {4{i_wdata[7:0]}};
        end else if (is_half) begin
            bmask_c = 4'b0011 << i_addr[1:0];
            wdata_c = {2{i_wdata[15:0]}};
        end else begin
            bmask_c = 4'b1111;
            wdata_c = i_wdata;
        end
        if (!i_mem_write) begin
            wdata_c = '0;
        end
    end

    assign timeout_hit = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    // A flush arriving in the same cycle as the response still kills the instruction.
    assign kill_now    = kill_q | i_flush;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        o_stall       = 1'b0;
        o_done        = 1'b0;
        bus.req_valid = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    o_stall   = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                o_stall       = 1'b1;
                bus.req_valid = 1'b1;
                if (bus.req_ready) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                o_stall = 1'b1;
                if (bus.rsp_valid || timeout_hit) begin
                    // Killed instructions never reach MEM/WB, so skip DONE.
                    state_nxt = kill_now ? IDLE : DONE;
                end
            end
            DONE: begin
                o_done    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign o_bus_err     = o_done & err_q;
    assign bus.req_we    = we_q;
    assign bus.req_addr  = addr_q;
    assign bus.req_wdata = wdata_q;
    assign bus.req_bmask = bmask_q;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            o_rdata      <= '0;
            o_misaligned <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            bmask_q      <= '0;
            off_q        <= '0;
            cnt          <= '0;
            kill_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            o_misaligned <= (state == IDLE) & access & misaligned;
            case (state)
                IDLE: begin
                    if (start) begin
                        we_q    <= i_mem_write;
                        addr_q  <= {i_addr[31:2], 2'b00};
                        wdata_q <= wdata_c;
                        bmask_q <= bmask_c;
                        off_q   <= i_addr[1:0];
                        err_q   <= 1'b0;
                    end
                end
                REQ: begin
                    kill_q <= kill_now;
                    if (bus.req_ready) begin
                        cnt <= '0;
                    end
                end
                RESP: begin
                    if (bus.rsp_valid) begin
                        if (!kill_now && !we_q) begin
                            o_rdata <= bus.rsp_rdata >> {off_q, 3'b000};
                        end
                        kill_q <= 1'b0;
                    end else if (timeout_hit) begin
                        if (!kill_now) begin
                            o_rdata <= '0;
                            err_q   <= 1'b1;
                        end
                        kill_q <= 1'b0;
                    end else begin
                        cnt    <= cnt + CNT_W'(1);
                        kill_q <= kill_now;
                    end
                end
                DONE: begin
                    err_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Scoreboard bench for mem_lsu: a driver plays pipeline and memory slave, a monitor checks outputs.
// Latency: n/a.
// Backpressure: the driver inserts random req_ready and response delays, timeouts and flushes.
module tb_mem_lsu;
    localparam int TO = 12;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  bmask;
    } req_t;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } done_t;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_valid = 1'b0, i_mem_read = 1'b0, i_mem_write = 1'b0, i_flush = 1'b0;
    logic [2:0]  i_funct3 = '0;
    logic [31:0] i_addr = '0, i_wdata = '0;
    logic        o_stall, o_done, o_misaligned, o_bus_err;
    logic [31:0] o_rdata;

    mem_lsu_if bus();

    mem_lsu #(.TIMEOUT_CYCLES(TO), .CNT_W(4)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .i_mem_read(i_mem_read),
        .i_mem_write(i_mem_write), .i_funct3(i_funct3), .i_addr(i_addr), .i_wdata(i_wdata),
        .i_flush(i_flush), .o_stall(o_stall), .o_rdata(o_rdata), .o_done(o_done),
        .o_misaligned(o_misaligned), .o_bus_err(o_bus_err), .bus(bus)
    );

    always #5 i_clk = ~i_clk;

    int          total = 0;
    int          bad = 0;
    req_t        req_q[$];
    done_t       done_q[$];
    int          mis_q[$];
    logic [31:0] exp_rdata = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares whatever the DUT presents against the scoreboard queues.
    always @(negedge i_clk) begin
        if (i_reset) begin
            if (bus.req_valid) begin
                if (req_q.size() == 0) begin
                    chk("unexpected_req", 32'd1, 32'd0);
                end else begin
                    chk("req_we", {31'd0, bus.req_we}, {31'd0, req_q[0].we});
                    chk("req_addr", bus.req_addr, req_q[0].addr);
                    chk("req_wdata", bus.req_wdata, req_q[0].wdata);
                    chk("req_bmask", {28'd0, bus.req_bmask}, {28'd0, req_q[0].bmask});
                    if (bus.req_ready) void'(req_q.pop_front());
                end
            end
            if (o_done) begin
                if (done_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    done_t d;
                    d = done_q.pop_front();
                    chk("bus_err", {31'd0, o_bus_err}, {31'd0, d.err});
                    chk("rdata", o_rdata, d.rdata);
                end
            end else if (o_bus_err) begin
                chk("bus_err_without_done", 32'd1, 32'd0);
            end
            if (o_misaligned) begin
                if (mis_q.size() == 0) begin
                    chk("unexpected_misaligned", 32'd1, 32'd0);
                end else begin
                    void'(mis_q.pop_front());
                    chk("mis_no_req", {31'd0, bus.req_valid}, 32'd0);
                end
            end
        end
    end

    // One MEM-stage instruction. rsp_dly < 0 means the slave never answers.
    task automatic do_txn(input logic is_st, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input int rdy_dly, input int rsp_dly,
                          input logic [31:0] rsp_dat, input logic kill);
        int    size;
        int    stalls;
        int    resp_cycles;
        req_t  r;
        done_t d;
        case (f3)
            3'd0, 3'd4: size = 1;
            3'd1, 3'd5: size = 2;
            default:    size = 4;
        endcase
        i_valid     = 1'b1;
        i_mem_read  = ~is_st;
        i_mem_write = is_st;
        i_funct3    = f3;
        i_addr      = addr;
        i_wdata     = wdata;
        if ((addr % size) != 0) begin
            mis_q.push_back(1);
            #1 chk("mis_stall", {31'd0, o_stall}, 32'd0);
            @(posedge i_clk); #1;
            i_valid = 1'b0;
            @(posedge i_clk); #1;
            return;
        end
        r.we    = is_st;
        r.addr  = addr & 32'hFFFF_FFFC;
        r.bmask = 4'((1 << size) - 1) << (addr % 4);
        r.wdata = '0;
        if (is_st) begin
            for (int i = 0; i < 4; i++) r.wdata[8*i +: 8] = wdata[8*(i % size) +: 8];
        end
        req_q.push_back(r);
        stalls = 0;
        #1 if (o_stall) stalls++;
        @(posedge i_clk); #1;
        i_valid = 1'b0; i_mem_read = 1'b0; i_mem_write = 1'b0;
        for (int k = 0; k < rdy_dly; k++) begin
            bus.req_ready = 1'b0;
            #1 if (o_stall) stalls++;
            @(posedge i_clk); #1;
        end
        bus.req_ready = 1'b1;
        #1 if (o_stall) stalls++;
        @(posedge i_clk); #1;
        bus.req_ready = 1'b0;
        resp_cycles = (rsp_dly < 0) ? TO : rsp_dly + 1;
        for (int k = 0; k < resp_cycles; k++) begin
            i_flush       = kill && (k == 0);
            bus.rsp_valid = (k == rsp_dly);
            bus.rsp_rdata = bus.rsp_valid ? rsp_dat : $urandom;
            #1 if (o_stall) stalls++;
            @(posedge i_clk); #1;
        end
        i_flush = 1'b0;
        bus.rsp_valid = 1'b0;
        if (!kill) begin
            if (rsp_dly < 0) exp_rdata = '0;
            else if (!is_st) exp_rdata = rsp_dat >> (8 * (addr % 4));
            d.err   = (rsp_dly < 0);
            d.rdata = exp_rdata;
            done_q.push_back(d);
        end
        chk("stall_cycles", stalls, 2 + rdy_dly + resp_cycles);
        #1 chk("stall_released", {31'd0, o_stall}, 32'd0);
        if (rsp_dly < 0) begin
            bus.rsp_valid = 1'b1;
            bus.rsp_rdata = $urandom | 32'h1;
        end
        @(posedge i_clk); #1;
        chk("rdata_held", o_rdata, exp_rdata);
        if (rsp_dly < 0) begin
            @(posedge i_clk); #1;
            bus.rsp_valid = 1'b0;
            chk("rdata_after_late_rsp", o_rdata, exp_rdata);
        end
    endtask

    initial begin
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rsp_rdata = '0;
        #3;
        chk("rst_stall", {31'd0, o_stall}, 32'd0);
        chk("rst_rdata", o_rdata, 32'd0);
        chk("rst_done", {31'd0, o_done}, 32'd0);
        chk("rst_req_valid", {31'd0, bus.req_valid}, 32'd0);
        chk("rst_misaligned", {31'd0, o_misaligned}, 32'd0);
        repeat (2) @(posedge i_clk);
        #1 i_reset = 1'b1;
        @(posedge i_clk); #1;

        do_txn(1'b0, 3'b010, 32'h100, 32'h0, 0, 1, 32'hDEADBEEF, 1'b0);
        do_txn(1'b0, 3'b000, 32'h203, 32'h0, 0, 0, 32'h11223344, 1'b0);
        do_txn(1'b0, 3'b101, 32'h202, 32'h0, 1, 2, 32'h11223344, 1'b0);
        do_txn(1'b1, 3'b000, 32'h301, 32'hAB, 3, 1, 32'h0, 1'b0);
        do_txn(1'b0, 3'b010, 32'h102, 32'h0, 0, 0, 32'h0, 1'b0);
        do_txn(1'b1, 3'b001, 32'h105, 32'h1234, 0, 0, 32'h0, 1'b0);
        do_txn(1'b0, 3'b010, 32'h140, 32'h0, 0, -1, 32'h0, 1'b0);
        do_txn(1'b0, 3'b010, 32'h120, 32'h0, 2, 0, 32'h55AA0FF0, 1'b0);
        do_txn(1'b0, 3'b010, 32'h110, 32'h0, 0, 3, 32'hCAFEF00D, 1'b1);
        do_txn(1'b0, 3'b001, 32'h132, 32'h0, 0, TO - 1, 32'h80001234, 1'b0);

        for (int n = 0; n < 150; n++) begin
            int sel;
            int rsp;
            if ($urandom_range(0, 7) == 0) begin
                // Flushed slot in IDLE: must stay invisible.
                i_valid = 1'b1; i_mem_read = 1'b1; i_flush = 1'b1;
                i_funct3 = 3'($urandom_range(0, 7)); i_addr = $urandom;
                #1 chk("flushed_slot_stall", {31'd0, o_stall}, 32'd0);
                @(posedge i_clk); #1;
                i_valid = 1'b0; i_mem_read = 1'b0; i_flush = 1'b0;
            end
            sel = $urandom_range(0, 9);
            rsp = (sel == 0) ? -1 : (sel == 1) ? TO - 1 : $urandom_range(0, 3);
            do_txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom,
                   $urandom_range(0, 3), rsp, $urandom, ($urandom_range(0, 5) == 0));
        end

        // Asynchronous reset while a request waits in REQ.
        do_txn(1'b0, 3'b010, 32'h400, 32'h0, 0, 0, 32'hA5A5A5A5, 1'b0);
        i_valid = 1'b1; i_mem_read = 1'b1; i_funct3 = 3'b010; i_addr = 32'h500;
        req_q.push_back('{1'b0, 32'h500, 32'h0, 4'hF});
        @(posedge i_clk); #1;
        i_valid = 1'b0; i_mem_read = 1'b0;
        #2 i_reset = 1'b0;
        #1;
        chk("arst_req_valid", {31'd0, bus.req_valid}, 32'd0);
        chk("arst_stall", {31'd0, o_stall}, 32'd0);
        chk("arst_rdata", o_rdata, 32'd0);
        chk("arst_req_addr", bus.req_addr, 32'd0);
        chk("arst_req_bmask", {28'd0, bus.req_bmask}, 32'd0);
        req_q.delete();
        exp_rdata = '0;
        @(posedge i_clk); #1;
        i_reset = 1'b1;
        repeat (3) @(posedge i_clk);
        #1;
        chk("req_q_drained", req_q.size(), 32'd0);
        chk("done_q_drained", done_q.size(), 32'd0);
        chk("mis_q_drained", mis_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
